// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller.
// Contents: FSM state encoding, the MMIO window base address and the width of
// the wait-state counter.
package mem_ctrl_pkg;

    localparam logic [31:0] MMIO_BASE = 32'h8000_0000;
    localparam int          WAIT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_IO    = 2'd3
    } state_t;

endpackage

// File: rtl/mem_ctrl_ram.sv
// Single-port synchronous RAM, 32-bit words, per-byte write enables.
// Ports:
//   clk   - clock, rising edge
//   addr  - word address
//   we    - byte write enables, bit i writes wdata[8i+7:8i]
//   wdata - write data
//   rdata - registered read data (old contents on a same-address write)
module mem_ctrl_ram #(
    parameter int    WORDS     = 4096,
    parameter int    ADDR_W    = 12,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/memory_controller.sv
// Memory stage: services single-outstanding loads/stores against on-chip RAM
// with WAIT_STATES extra busy cycles per access.
// Ports:
//   clk, reset (async, active low)
//   load / store                 - requests, sampled only while idle (store wins)
//   memory_access_address        - byte address, bits [1:0] ignored
//   memory_write_data / _mask    - store data and byte enables
//   memory_read_busy / _write_busy - registered busy handshakes
//   memory_read_data             - last completed read word, held until the next read
// Optional feature, macro MEMORY_CONTROLLER_MMIO_EN: requests with address[31]=1
// go out on the io_* handshake instead of RAM (no wait states applied).
module memory_controller #(
    parameter int    MEM_WORDS   = 4096,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        store,
    input  logic [31:0] memory_access_address,
    input  logic [31:0] memory_write_data,
    input  logic [3:0]  memory_write_mask,
    output logic        memory_read_busy,
    output logic        memory_write_busy,
    output logic [31:0] memory_read_data
`ifdef MEMORY_CONTROLLER_MMIO_EN
    ,
    output logic        io_valid,
    output logic        io_write,
    output logic [31:0] io_addr,
    output logic [31:0] io_wdata,
    output logic [3:0]  io_wmask,
    input  logic [31:0] io_rdata,
    input  logic        io_ready
`endif
);
    import mem_ctrl_pkg::*;

    localparam int ADDR_W = $clog2(MEM_WORDS);

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] cnt_reg, cnt_next;
    logic [ADDR_W-1:0] word_reg, word_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [3:0]        wmask_reg, wmask_next;
    logic              read_busy_reg, read_busy_next;
    logic              write_busy_reg, write_busy_next;
    logic [31:0]       rdata_reg, rdata_next;

    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_we;
    logic [31:0]       ram_rdata;

`ifdef MEMORY_CONTROLLER_MMIO_EN
    logic              io_valid_reg, io_valid_next;
    logic              io_write_reg, io_write_next;
    logic [31:0]       io_addr_reg, io_addr_next;
    logic              is_io;
    assign is_io = |(memory_access_address & MMIO_BASE);
`endif

    // Address bits outside the word index only matter for the IO decode.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{memory_access_address[31:ADDR_W+2], memory_access_address[1:0]};

    mem_ctrl_ram #(
        .WORDS     (MEM_WORDS),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (wdata_reg),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        word_next       = word_reg;
        wdata_next      = wdata_reg;
        wmask_next      = wmask_reg;
        read_busy_next  = read_busy_reg;
        write_busy_next = write_busy_reg;
        rdata_next      = rdata_reg;
        ram_addr        = word_reg;
        ram_we          = 4'b0000;
`ifdef MEMORY_CONTROLLER_MMIO_EN
        io_valid_next   = io_valid_reg;
        io_write_next   = io_write_reg;
        io_addr_next    = io_addr_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                // Present the incoming address while idle so the registered
                // RAM read is already valid one edge after acceptance; this
                // is what lets WAIT_STATES=0 complete in a single busy cycle.
                ram_addr = memory_access_address[ADDR_W+1:2];
                if (store || load) begin
                    word_next = memory_access_address[ADDR_W+1:2];
                    cnt_next  = WAIT_W'(WAIT_STATES);
                    if (store) begin
                        wdata_next = memory_write_data;
                        wmask_next = memory_write_mask;
                    end
`ifdef MEMORY_CONTROLLER_MMIO_EN
                    io_addr_next  = memory_access_address;
                    io_write_next = store;
                    if (is_io) begin
                        state_next    = ST_IO;
                        io_valid_next = 1'b1;
                    end else
`endif
                    if (store) begin
                        state_next = ST_WRITE;
                    end else begin
                        state_next = ST_READ;
                    end
                    write_busy_next = store;
                    read_busy_next  = !store;
                end
            end
            ST_READ: begin
                if (cnt_reg == '0) begin
                    rdata_next     = ram_rdata;
                    read_busy_next = 1'b0;
                    state_next     = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_WRITE: begin
                if (cnt_reg == '0) begin
                    ram_we          = wmask_reg;
                    write_busy_next = 1'b0;
                    state_next      = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
`ifdef MEMORY_CONTROLLER_MMIO_EN
            ST_IO: begin
                if (io_ready) begin
                    if (!io_write_reg) begin
                        rdata_next = io_rdata;
                    end
                    io_valid_next   = 1'b0;
                    read_busy_next  = 1'b0;
                    write_busy_next = 1'b0;
                    state_next      = ST_IDLE;
                end
            end
`endif
            default: begin
                state_next      = ST_IDLE;
                read_busy_next  = 1'b0;
                write_busy_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            word_reg       <= '0;
            wdata_reg      <= '0;
            wmask_reg      <= '0;
            read_busy_reg  <= 1'b0;
            write_busy_reg <= 1'b0;
            rdata_reg      <= '0;
`ifdef MEMORY_CONTROLLER_MMIO_EN
            io_valid_reg   <= 1'b0;
            io_write_reg   <= 1'b0;
            io_addr_reg    <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            word_reg       <= word_next;
            wdata_reg      <= wdata_next;
            wmask_reg      <= wmask_next;
            read_busy_reg  <= read_busy_next;
            write_busy_reg <= write_busy_next;
            rdata_reg      <= rdata_next;
`ifdef MEMORY_CONTROLLER_MMIO_EN
            io_valid_reg   <= io_valid_next;
            io_write_reg   <= io_write_next;
            io_addr_reg    <= io_addr_next;
`endif
        end
    end

    assign memory_read_busy  = read_busy_reg;
    assign memory_write_busy = write_busy_reg;
    assign memory_read_data  = rdata_reg;

`ifdef MEMORY_CONTROLLER_MMIO_EN
    assign io_valid = io_valid_reg;
    assign io_write = io_write_reg;
    assign io_addr  = io_addr_reg;
    assign io_wdata = wdata_reg;
    assign io_wmask = wmask_reg;
`endif

`ifndef SYNTHESIS
    // Simultaneous load and store: the store is taken and the load is lost.
    always @(posedge clk) begin
        if (reset && state_reg == ST_IDLE) begin
            assert (!(load && store))
            else $warning("memory_controller: load and store together, load dropped");
        end
    end
`endif

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench: three controllers (WAIT_STATES 0, 2, 3) with independent
// request inputs and a shared reset; vector table plus hand-written sequences.
module tb_memory_controller;

    localparam int N  = 3;
    localparam int MW = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld   [N];
    logic        st   [N];
    logic [31:0] addr [N];
    logic [31:0] wd   [N];
    logic [3:0]  wm   [N];
    logic        rb   [N];
    logic        wb   [N];
    logic [31:0] rd   [N];
`ifdef MEMORY_CONTROLLER_MMIO_EN
    logic        iov   [N];
    logic        iow   [N];
    logic [31:0] ioa   [N];
    logic [31:0] iowd  [N];
    logic [3:0]  iowm  [N];
    logic [31:0] iord  [N];
    logic        iordy [N];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            memory_controller #(
                .MEM_WORDS   (MW),
                .WAIT_STATES ((gi == 0) ? 0 : (gi == 1) ? 2 : 3),
                .INIT_FILE   ("")
            ) u_dut (
                .clk                   (clk),
                .reset                 (reset),
                .load                  (ld[gi]),
                .store                 (st[gi]),
                .memory_access_address (addr[gi]),
                .memory_write_data     (wd[gi]),
                .memory_write_mask     (wm[gi]),
                .memory_read_busy      (rb[gi]),
                .memory_write_busy     (wb[gi]),
                .memory_read_data      (rd[gi])
`ifdef MEMORY_CONTROLLER_MMIO_EN
                ,
                .io_valid              (iov[gi]),
                .io_write              (iow[gi]),
                .io_addr               (ioa[gi]),
                .io_wdata              (iowd[gi]),
                .io_wmask              (iowm[gi]),
                .io_rdata              (iord[gi]),
                .io_ready              (iordy[gi])
`endif
            );
        end
    endgenerate

    function automatic int ws_of(input int i);
        case (i)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One request, then count busy cycles (sampled on negedges) until idle.
    task automatic access(input int i, input logic l, input logic s, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] m,
                          output int rc, output int wc);
        logic done;
        @(negedge clk);
        ld[i] = l; st[i] = s; addr[i] = a; wd[i] = d; wm[i] = m;
        @(posedge clk);
        #1;
        ld[i] = 1'b0; st[i] = 1'b0;
        rc = 0; wc = 0; done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!rb[i] && !wb[i]) begin
                done = 1'b1;
                break;
            end
            if (rb[i]) rc++;
            if (wb[i]) wc++;
        end
        check("busy_timeout", 32'(done), 32'd1);
        $display("txn inst=%0d load=%b store=%b addr=%h wdata=%h mask=%h rdata=%h rbusy=%0d wbusy=%0d",
                 i, l, s, a, d, m, rd[i], rc, wc);
    endtask

    typedef struct {
        int          idx;
        logic        l;
        logic        s;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt [12];

    initial begin
        int rc, wc, cnt, seen, ws;
        logic done;

        for (int i = 0; i < N; i++) begin
            ld[i] = 1'b0; st[i] = 1'b0; addr[i] = '0; wd[i] = '0; wm[i] = '0;
`ifdef MEMORY_CONTROLLER_MMIO_EN
            iord[i] = '0; iordy[i] = 1'b0;
`endif
        end

        vt[0]  = '{0, 1'b0, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0000_0000};
        vt[1]  = '{0, 1'b0, 1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0000_0000};
        vt[2]  = '{0, 1'b1, 1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h11BB_33DD};
        vt[3]  = '{1, 1'b0, 1'b1, 32'h0000_0040, 32'hCAFE_BABE, 4'hF, 32'h0000_0000};
        vt[4]  = '{1, 1'b1, 1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'hCAFE_BABE};
        vt[5]  = '{1, 1'b0, 1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'h0, 32'hCAFE_BABE};
        vt[6]  = '{1, 1'b1, 1'b0, 32'h0000_0041, 32'h0,         4'h0, 32'hCAFE_BABE};
        vt[7]  = '{2, 1'b0, 1'b1, 32'h0000_0400, 32'h55AA_55AA, 4'hF, 32'h0000_0000};
        vt[8]  = '{2, 1'b1, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h55AA_55AA};
        vt[9]  = '{2, 1'b0, 1'b1, 32'h0000_000C, 32'h0BAD_F00D, 4'hF, 32'h55AA_55AA};
        vt[10] = '{2, 1'b1, 1'b0, 32'h0000_000C, 32'h0,         4'h0, 32'h0BAD_F00D};
        vt[11] = '{0, 1'b0, 1'b1, 32'h0000_0024, 32'h0000_0001, 4'hF, 32'h11BB_33DD};

        // Reset state
        reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check("reset_rbusy", 32'(rb[i]), 32'd0);
            check("reset_wbusy", 32'(wb[i]), 32'd0);
            check("reset_rdata", rd[i], 32'h0);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Vector table: busy length WAIT_STATES+1 on the selected handshake,
        // read data as expected when busy falls.
        for (int v = 0; v < 12; v++) begin
            ws = ws_of(vt[v].idx);
            access(vt[v].idx, vt[v].l, vt[v].s, vt[v].a, vt[v].d, vt[v].m, rc, wc);
            check($sformatf("vec%0d_rbusy_cycles", v), 32'(rc), (vt[v].l && !vt[v].s) ? 32'(ws + 1) : 32'd0);
            check($sformatf("vec%0d_wbusy_cycles", v), 32'(wc), vt[v].s ? 32'(ws + 1) : 32'd0);
            check($sformatf("vec%0d_rdata", v), rd[vt[v].idx], vt[v].exp_rd);
        end

        // Reset in the 2nd busy cycle of a write discards it.
        access(2, 1'b0, 1'b1, 32'h10, 32'h0123_4567, 4'hF, rc, wc);
        @(negedge clk);
        st[2] = 1'b1; addr[2] = 32'h10; wd[2] = 32'hDEAD_BEEF; wm[2] = 4'hF;
        @(posedge clk);
        #1;
        st[2] = 1'b0;
        @(negedge clk);
        check("midwrite_busy_1st", 32'(wb[2]), 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midwrite_busy_cleared", 32'(wb[2]), 32'd0);
        check("midwrite_rdata_cleared", rd[2], 32'h0);
        @(negedge clk);
        reset = 1'b1;
        access(2, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, rc, wc);
        check("midwrite_ram_kept", rd[2], 32'h0123_4567);

        // Load and store together: only the write happens.
        access(2, 1'b1, 1'b1, 32'h4, 32'h7777_7777, 4'hF, rc, wc);
        check("collide_rbusy", 32'(rc), 32'd0);
        check("collide_wbusy", 32'(wc), 32'd4);
        check("collide_rdata_held", rd[2], 32'h0123_4567);
        access(2, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, rc, wc);
        check("collide_write_done", rd[2], 32'h7777_7777);

        // Load held high during a write is ignored, then taken in the first idle cycle.
        @(negedge clk);
        st[1] = 1'b1; addr[1] = 32'h60; wd[1] = 32'h1357_2468; wm[1] = 4'hF;
        @(posedge clk);
        #1;
        st[1] = 1'b0; ld[1] = 1'b1; addr[1] = 32'h40;
        cnt = 0; seen = 0; done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rb[1]) seen++;
            if (!wb[1]) begin
                done = 1'b1;
                break;
            end
            cnt++;
        end
        check("ignore_timeout", 32'(done), 32'd1);
        check("ignore_wbusy_cycles", 32'(cnt), 32'd3);
        check("ignore_no_read", 32'(seen), 32'd0);
        @(posedge clk);
        #1;
        ld[1] = 1'b0;
        cnt = 0; done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!rb[1]) begin
                done = 1'b1;
                break;
            end
            cnt++;
        end
        check("idle_load_timeout", 32'(done), 32'd1);
        check("idle_load_rbusy_cycles", 32'(cnt), 32'd3);
        check("idle_load_rdata", rd[1], 32'hCAFE_BABE);
        $display("txn inst=1 load held through write, accepted when idle rdata=%h", rd[1]);
        access(1, 1'b1, 1'b0, 32'h60, 32'h0, 4'h0, rc, wc);
        check("ignore_write_done", rd[1], 32'h1357_2468);

`ifdef MEMORY_CONTROLLER_MMIO_EN
        // IO read: ready in the 5th busy cycle, RAM at the same word untouched.
        access(0, 1'b0, 1'b1, 32'h8, 32'h600D_CAFE, 4'hF, rc, wc);
        @(negedge clk);
        ld[0] = 1'b1; addr[0] = 32'h8000_0008;
        @(posedge clk);
        #1;
        ld[0] = 1'b0;
        cnt = 0; seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rb[0]) cnt++;
            if (iov[0]) seen++;
        end
        iordy[0] = 1'b1; iord[0] = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        iordy[0] = 1'b0; iord[0] = '0;
        @(negedge clk);
        check("io_busy_cycles", 32'(cnt), 32'd5);
        check("io_valid_cycles", 32'(seen), 32'd5);
        check("io_busy_done", 32'(rb[0]), 32'd0);
        check("io_valid_done", 32'(iov[0]), 32'd0);
        check("io_rdata", rd[0], 32'hCAFE_F00D);
        $display("txn inst=0 io load addr=80000008 rdata=%h busy=%0d", rd[0], cnt);
        access(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, rc, wc);
        check("io_ram_untouched", rd[0], 32'h600D_CAFE);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
